uart_param: RTL

- Parametrised full-duplex UART transceiver; next generation of the fixed 8N1 `uart` block.
- Adds the following over `uart`:
  - configurable data width, parity mode and stop-bit count;
  - baud rate derived from parameters;
  - 16x-oversampled receiver with glitch rejection;
  - parity, framing and overrun error reporting.
- Keeps the existing `wr_en`/`tx_busy` and `rdy`/`rdy_clr` handshakes, so current loopback benches port directly.

---
 rtl/uart_param.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable width, parity and stop bits,
// baud derived from CLK_FREQ/BAUD, 16x-oversampled receiver with error flags.
`timescale 1ns/1ps
module uart_param #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned TX_DIV     = CLK_FREQ / BAUD;
  localparam int unsigned RX_DIV     = CLK_FREQ / (16 * BAUD);
  localparam int unsigned TX_LEN_MAX = STOP_BITS * TX_DIV;
  localparam int unsigned TX_CNT_W   = (TX_LEN_MAX > 1) ? $clog2(TX_LEN_MAX) : 1;
  localparam int unsigned RX_DIV_W   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int unsigned BIT_W      = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Expected parity bit for the configured mode (even: XOR, odd: inverted XOR)
  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : (^d);
  endfunction

  logic [2:0]           tx_state_q, tx_state_d;
  logic [TX_CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_busy_q, tx_busy_d;

  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_s2_q, rx_s2_d;
  logic [RX_DIV_W-1:0]  rx_div_q, rx_div_d;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_mism_q, rx_mism_d;
  logic                 rdy_q, rdy_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick_c;

  // Transmitter: one counter times every bit; stop phase runs STOP_BITS bit-times
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (wr_en) begin
          tx_shift_d = din;
          tx_par_d   = par_bit(din);
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
        if (tx_cnt_q == TX_CNT_W'(TX_DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
        if (tx_cnt_q == TX_CNT_W'(TX_DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d       = tx_par_q;
              tx_state_d = S_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = S_STOP;
            end
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
            tx_d     = tx_shift_q[1];
          end
        end
      end
      S_PARITY: begin
        tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
        if (tx_cnt_q == TX_CNT_W'(TX_DIV - 1)) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d     = 1'b1;
        tx_cnt_d = tx_cnt_q + TX_CNT_W'(1);
        if (tx_cnt_q == TX_CNT_W'(TX_LEN_MAX - 1)) begin
          tx_cnt_d   = '0;
          tx_busy_d  = 1'b0;
          tx_state_d = S_IDLE;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  assign tick_c = (rx_div_q == RX_DIV_W'(RX_DIV - 1));

  // Receiver: sample at mid-bit on the oversample tick; completion beats rdy_clr
  always_comb begin
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    rx_div_d     = tick_c ? '0 : rx_div_q + RX_DIV_W'(1);
    rx_state_d   = rx_state_q;
    rx_tick_d    = rx_tick_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_mism_d    = rx_mism_q;
    rdy_d        = rdy_q;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    if (rdy_clr) begin
      rdy_d        = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_div_d   = '0;
          rx_tick_d  = '0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            rx_tick_d = rx_tick_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
              rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_bit_d = rx_bit_q + BIT_W'(1);
            end
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_tick_d  = '0;
            rx_mism_d  = rx_s2_q ^ par_bit(rx_shift_q);
            rx_state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick_c) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd15) begin
            rx_tick_d    = '0;
            dout_d       = rx_shift_q;
            parity_err_d = (PARITY != 0) ? rx_mism_q : 1'b0;
            frame_err_d  = ~rx_s2_q;
            rdy_d        = 1'b1;
            overrun_d    = ~rdy_clr & (overrun_q | rdy_q);
            rx_state_d   = S_IDLE;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst) begin
    if (!rst) begin
      tx_state_q   <= S_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_div_q     <= '0;
      rx_state_q   <= S_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_mism_q    <= 1'b0;
      rdy_q        <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_div_q     <= rx_div_d;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_mism_q    <= rx_mism_d;
      rdy_q        <= rdy_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = tx_busy_q;
  assign rdy        = rdy_q;
  assign dout       = dout_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
